l1_norm_accum: RTL and testbench

- Streaming L1-norm engine for complex vectors, used in the MIMO/QR datapath for column-norm estimation and pivot selection.
- Each beat carries LANES complex entries. The block computes the sum of |re|+|im| over all lanes and accumulates that sum over a multi-beat frame delimited by i_last.
- At the end of each frame it emits one scaled, saturated norm.
- It generalises the fixed four-entry norm unit: lane count, component width, output scaling and frame length are all parameters.

---
 rtl/l1_norm_accum.sv | 142 ++++++++++++++
 tb/tb_l1_norm_accum.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/l1_norm_accum.sv
// Streaming L1-norm engine: sums |re|+|im| over all lanes of each beat, accumulates per
// frame (delimited by i_last) and emits one scaled, saturated norm per frame.
module l1_norm_accum #(
    parameter int unsigned DW        = 10,
    parameter int unsigned LANES     = 4,
    parameter int unsigned SHIFT     = 2,
    parameter int unsigned OW        = 10,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned BW       = $clog2(MAX_BEATS) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic                    i_last,
    input  logic [LANES*2*DW-1:0]   i_data,
    output logic                    o_valid,
    output logic [OW-1:0]           o_norm,
    output logic                    o_sat,
    output logic [BW-1:0]           o_beats
);

    localparam int unsigned NC = 2 * LANES;
    localparam int unsigned SW = DW + 1 + $clog2(NC);
    localparam int unsigned AW = SW + $clog2(MAX_BEATS);
    localparam int unsigned NP = 1 << $clog2(NC);

    // Stage 1: per-component magnitudes
    logic [DW:0]     mag_d [NC];
    logic [DW:0]     mag_q [NC];
    logic            s1_valid_q, s1_last_q;

    always_comb begin
        for (int i = 0; i < int'(NC); i++) begin
            logic [DW:0] ext;
            ext = {i_data[i*DW+DW-1], i_data[i*DW +: DW]};
            // One extra bit so the most negative input maps to +2^(DW-1) instead of wrapping.
            mag_d[i] = ext[DW] ? (~ext + 1'b1) : ext;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NC); i++) mag_q[i] <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NC); i++) mag_q[i] <= mag_d[i];
            s1_valid_q <= i_valid;
            s1_last_q  <= i_valid & i_last;
        end
    end

    // Stage 2: balanced binary adder tree, leaves padded to a power of two
    logic [SW-1:0]   tree [1:2*NP-1];
    logic [SW-1:0]   sum_q;
    logic            s2_valid_q, s2_last_q;

    always_comb begin
        for (int i = 1; i < int'(2 * NP); i++) tree[i] = '0;
        for (int i = 0; i < int'(NP); i++) begin
            if (i < int'(NC)) tree[int'(NP) + i] = {{(SW-DW-1){1'b0}}, mag_q[i]};
        end
        for (int i = int'(NP) - 1; i >= 1; i--) tree[i] = tree[2*i] + tree[2*i+1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sum_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            sum_q      <= tree[1];
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // Stage 3: saturating frame accumulator and beat counter
    logic [AW-1:0]   acc_q, acc_base;
    logic [AW:0]     acc_sum;
    logic [AW-1:0]   acc_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic            first_q;
    logic            s3_done_q;

    always_comb begin
        acc_base = first_q ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + {{(AW+1-SW){1'b0}}, sum_q};
        acc_d    = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
        if (first_q)       cnt_d = BW'(1);
        else if (&cnt_q)   cnt_d = cnt_q;
        else               cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            s3_done_q <= 1'b0;
        end else begin
            s3_done_q <= s2_valid_q & s2_last_q;
            if (s2_valid_q) begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                first_q <= s2_last_q;
            end
        end
    end

    // Output stage: scale, clip and register the finished frame
    logic [AW-1:0]   shifted;
    logic [OW-1:0]   norm_d;
    logic            clip;

    assign shifted = acc_q >> SHIFT;

    if (AW > OW) begin : g_clip
        assign clip   = |shifted[AW-1:OW];
        assign norm_d = clip ? '1 : shifted[OW-1:0];
    end else begin : g_noclip
        assign clip   = 1'b0;
        assign norm_d = OW'(shifted);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_norm  <= '0;
            o_sat   <= 1'b0;
            o_beats <= '0;
        end else begin
            o_valid <= s3_done_q;
            if (s3_done_q) begin
                o_norm  <= norm_d;
                o_sat   <= clip;
                o_beats <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_l1_norm_accum.sv
// Scoreboard bench for l1_norm_accum: directed frames push expected results, a negedge
// monitor pops and checks value and latency on every o_valid pulse.
module tb_l1_norm_accum;

    localparam int unsigned DW    = 10;
    localparam int unsigned LANES = 4;
    localparam int unsigned OW    = 10;
    localparam int unsigned BW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  valid;
    logic                  last;
    logic [LANES*2*DW-1:0] data;
    logic                  o_valid;
    logic [OW-1:0]         o_norm;
    logic                  o_sat;
    logic [BW-1:0]         o_beats;

    l1_norm_accum #(
        .DW(DW), .LANES(LANES), .SHIFT(2), .OW(OW), .MAX_BEATS(16)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (valid),
        .i_last  (last),
        .i_data  (data),
        .o_valid (o_valid),
        .o_norm  (o_norm),
        .o_sat   (o_sat),
        .o_beats (o_beats)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int norm;
        int sat;
        int beats;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got o_valid=1 norm=%0d, expected no pulse", o_norm);
            end else begin
                e_mon = sb.pop_front();
                check("norm", int'(o_norm), e_mon.norm);
                check("sat", int'(o_sat), e_mon.sat);
                check("beats", int'(o_beats), e_mon.beats);
                check("latency", cyc, e_mon.cyc);
            end
        end
    end

    function automatic logic [LANES*2*DW-1:0] pack(input int re, input int im);
        logic [LANES*2*DW-1:0] d;
        logic [DW-1:0]         r;
        logic [DW-1:0]         m;
        r = re[DW-1:0];
        m = im[DW-1:0];
        for (int k = 0; k < int'(LANES); k++) d[k*2*DW +: 2*DW] = {m, r};
        return d;
    endfunction

    task automatic beat(input int re, input int im, input logic lst,
                        input int en, input int es, input int eb);
        exp_t e;
        valid = 1'b1;
        last  = lst;
        data  = pack(re, im);
        @(posedge clk);
        #1;
        if (lst) begin
            e.norm  = en;
            e.sat   = es;
            e.beats = eb;
            e.cyc   = cyc + 3;
            sb.push_back(e);
        end
        valid = 1'b0;
        last  = 1'b0;
        data  = '0;
    endtask

    // Idle cycles; optionally toggles i_last with i_valid low, which must be ignored.
    task automatic idle(input int n, input logic stray_last);
        for (int i = 0; i < n; i++) begin
            last = stray_last;
            data = pack(7, 7);
            @(posedge clk);
            #1;
        end
        last = 1'b0;
        data = '0;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        data  = '0;
        @(negedge clk);
        check("rst_valid", int'(o_valid), 0);
        check("rst_norm", int'(o_norm), 0);
        check("rst_sat", int'(o_sat), 0);
        check("rst_beats", int'(o_beats), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2, 1'b0);

        // single beat: 8 * 100 = 800, >>2 = 200
        beat(100, -100, 1'b1, 200, 0, 1);
        idle(8, 1'b0);

        // most negative: 8 * 512 = 4096, >>2 = 1024 -> clipped
        beat(-512, -512, 1'b1, 1023, 1, 1);
        idle(8, 1'b0);

        // three consecutive beats: 3 * 8 = 24, >>2 = 6
        beat(1, 1, 1'b0, 0, 0, 0);
        beat(1, 1, 1'b0, 0, 0, 0);
        beat(1, 1, 1'b1, 6, 0, 3);
        idle(8, 1'b0);

        // same frame with idle gaps and stray i_last while invalid
        beat(1, 1, 1'b0, 0, 0, 0);
        idle(2, 1'b1);
        beat(1, 1, 1'b0, 0, 0, 0);
        idle(2, 1'b1);
        beat(1, 1, 1'b1, 6, 0, 3);
        idle(8, 1'b0);
        check("hold_norm", int'(o_norm), 6);
        check("hold_beats", int'(o_beats), 3);

        // reset mid-frame discards partial data
        beat(50, 50, 1'b0, 0, 0, 0);
        beat(50, 50, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_norm", int'(o_norm), 0);
        check("midrst_beats", int'(o_beats), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        beat(4, 0, 1'b1, 4, 0, 1);
        idle(8, 1'b0);

        // back-to-back single-beat frames
        beat(100, -100, 1'b1, 200, 0, 1);
        beat(1, 1, 1'b1, 2, 0, 1);
        idle(10, 1'b0);

        check("sb_drained", sb.size(), 0);
        check("final_norm", int'(o_norm), 2);
        check("final_valid", int'(o_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
